// File: rtl/uart_io_receiver_pkg.sv
// Shared constants and types for the UART receive path.
//   UART_STATUS_ADDR / UART_DATA_ADDR : default io addresses of the two registers
//   STATUS_*_BIT                      : bit positions inside the status word
//   uart_rx_state_t                   : receive FSM states
package uart_io_receiver_pkg;

  localparam logic [31:0] UART_STATUS_ADDR = 32'h18;
  localparam logic [31:0] UART_DATA_ADDR   = 32'h1c;

  localparam int STATUS_AVAIL_BIT     = 0;
  localparam int STATUS_OVERRUN_BIT   = 1;
  localparam int STATUS_FRAME_ERR_BIT = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_io_receiver_sync_fifo.sv
// Small synchronous FIFO used to buffer received bytes.
//   clk, reset_n        : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data     : write request; ignored when full unless a pop happens in the same cycle
//   pop                 : read request; ignored when empty
//   pop_data            : head entry (combinational, valid while not empty)
//   full, empty, count  : occupancy status
module sync_fifo
  import uart_io_receiver_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_COUNT);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_io_receiver.sv
// UART 8N1 receiver with a byte FIFO and an io-mapped status/data register pair.
//   clk, reset_n   : system clock, asynchronous active-low reset
//   uart_rx        : serial input, idle high, asynchronous to clk
//   io_read_en     : read strobe from the core
//   io_address     : read address (STATUS_ADDR or DATA_ADDR)
//   io_read_data   : registered read data, updated the cycle after io_read_en
//   rx_data_avail  : FIFO not empty
module uart_io_receiver
  import uart_io_receiver_pkg::*;
#(
  parameter int          BAUD_DIVIDE = 434,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] STATUS_ADDR = UART_STATUS_ADDR,
  parameter logic [31:0] DATA_ADDR   = UART_DATA_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rx,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  output logic [31:0] io_read_data,
  output logic        rx_data_avail
);
  localparam int CNT_W = $clog2(BAUD_DIVIDE);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIVIDE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_DIVIDE / 2);

  logic           sync1_q, rx_s_q;
  uart_rx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           frame_err_q, frame_err_d;
  logic           overrun_q, overrun_d;
  logic [31:0]    rd_data_q, rd_data_d;

  logic           push, frame_err_set, overrun_set;
  logic           status_rd, data_rd, pop;
  logic [7:0]     fifo_head;
  logic           fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic [31:0]    status_word;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_data_avail = (fifo_count != '0);
  assign io_read_data  = rd_data_q;

  // Receive FSM: start bit is confirmed at its midpoint, after which every
  // full bit period lands on the middle of the next bit.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_d       = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        // A held-low line must not be mistaken for a stream of start bits.
        cnt_d = '0;
        if (rx_s_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // io read port, sticky flags and FIFO pop.
  always_comb begin
    status_rd   = io_read_en && (io_address == STATUS_ADDR);
    data_rd     = io_read_en && (io_address == DATA_ADDR);
    pop         = data_rd && !fifo_empty;
    overrun_set = push && fifo_full && !pop;

    // A set in the same cycle as a clearing read wins.
    frame_err_d = frame_err_set | (frame_err_q & ~status_rd);
    overrun_d   = overrun_set | (overrun_q & ~status_rd);

    status_word = '0;
    status_word[STATUS_AVAIL_BIT]     = rx_data_avail;
    status_word[STATUS_OVERRUN_BIT]   = overrun_q;
    status_word[STATUS_FRAME_ERR_BIT] = frame_err_q;

    rd_data_d = rd_data_q;
    if (io_read_en) begin
      if (status_rd)    rd_data_d = status_word;
      else if (data_rd) rd_data_d = fifo_empty ? 32'h0 : {24'h0, fifo_head};
      else              rd_data_d = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      sync1_q     <= uart_rx;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_uart_io_receiver.sv
// Self-checking bench for uart_io_receiver: directed scenarios plus a random
// mix of frames and reads, compared against a queue-based model.
module tb_uart_io_receiver;
  localparam int          B        = 40;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] STATUS_A = 32'h18;
  localparam logic [31:0] DATA_A   = 32'h1c;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        uart_rx;
  logic        io_read_en;
  logic [31:0] io_address;
  logic [31:0] io_read_data;
  logic        rx_data_avail;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  q[$];
  logic        m_ferr, m_ovr;
  logic [31:0] last_exp;
  int          lat;

  always #5 clk = ~clk;

  uart_io_receiver #(
    .BAUD_DIVIDE (B),
    .FIFO_DEPTH  (DEPTH),
    .STATUS_ADDR (STATUS_A),
    .DATA_ADDR   (DATA_A)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .uart_rx       (uart_rx),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_read_data  (io_read_data),
    .rx_data_avail (rx_data_avail)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    uart_rx = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    drive(1'b0, B);
    for (int i = 0; i < 8; i++) drive(b[i], B);
    drive(stop_lvl, B);
    uart_rx = 1'b1;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic io_read(input logic [31:0] a, output logic [31:0] d);
    io_read_en = 1'b1;
    io_address = a;
    tick();
    io_read_en = 1'b0;
    d = io_read_data;
  endtask

  task automatic read_status(input string tag);
    logic [31:0] exp, d;
    exp = {29'b0, m_ferr, m_ovr, (q.size() != 0)};
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    io_read(STATUS_A, d);
    check(tag, d, exp);
    last_exp = exp;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] exp, d;
    exp = (q.size() != 0) ? {24'h0, q.pop_front()} : 32'h0;
    io_read(DATA_A, d);
    check(tag, d, exp);
    last_exp = exp;
  endtask

  initial begin
    logic [7:0]  b, nb;
    logic [31:0] d, exp, addr;
    int          r;

    m_ferr = 1'b0; m_ovr = 1'b0;
    reset_n = 1'b0; uart_rx = 1'b1; io_read_en = 1'b0; io_address = '0;
    repeat (3) tick();
    check("reset_read_data", io_read_data, 32'h0);
    check("reset_avail", {31'b0, rx_data_avail}, 32'h0);
    reset_n = 1'b1;
    drive(1'b1, 2 * B);
    read_status("reset_status");

    // Single byte, with arrival latency measured from the start edge.
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!rx_data_avail && lat < 12 * B) begin
          tick();
          lat++;
        end
      end
    join
    model_push(8'hA5);
    check("a5_avail", {31'b0, rx_data_avail}, 32'h1);
    check("a5_latency_window", {31'b0, (lat >= (19 * B) / 2) && (lat <= (21 * B) / 2)}, 32'h1);
    drive(1'b1, B);
    read_status("a5_status");
    read_data("a5_data");
    check("a5_avail_after", {31'b0, rx_data_avail}, 32'h0);

    // Nine bytes into an eight-entry FIFO.
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1);
      model_push(8'(i));
      drive(1'b1, $urandom_range(2, B));
    end
    read_status("overrun_status");
    for (int i = 0; i < 9; i++) read_data($sformatf("overrun_data%0d", i));
    read_status("overrun_cleared");

    // Framing error followed by a held-low line.
    b = 8'($urandom_range(0, 255));
    drive(1'b0, B);
    for (int i = 0; i < 8; i++) drive(b[i], B);
    drive(1'b0, B);
    m_ferr = 1'b1;
    drive(1'b0, 3 * B);
    read_status("break_status");
    check("break_avail", {31'b0, rx_data_avail}, 32'h0);
    drive(1'b1, 2 * B);
    nb = 8'($urandom_range(0, 255));
    send_frame(nb, 1'b1);
    model_push(nb);
    drive(1'b1, B);
    read_data("after_break_data");

    // Short glitch on an idle line.
    drive(1'b0, B / 4);
    drive(1'b1, 2 * B);
    read_status("glitch_status");
    check("glitch_avail", {31'b0, rx_data_avail}, 32'h0);

    // Full FIFO: DATA read lands on the same edge as the next push.
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      model_push(b);
      drive(1'b1, $urandom_range(2, B));
    end
    drive(1'b1, 2 * B);
    nb = 8'($urandom_range(0, 255));
    if (lat < 1) lat = 1;
    d = '0;
    fork
      send_frame(nb, 1'b1);
      begin
        repeat (lat - 1) tick();
        io_read(DATA_A, d);
      end
    join
    exp = {24'h0, q.pop_front()};
    q.push_back(nb);
    check("collide_data", d, exp);
    drive(1'b1, B);
    read_status("collide_status");
    for (int i = 0; i < DEPTH; i++) read_data($sformatf("collide_drain%0d", i));

    // Reset in the middle of a frame with bytes buffered.
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      model_push(b);
      drive(1'b1, $urandom_range(2, B));
    end
    read_status("prereset_status");
    drive(1'b0, B);
    drive(1'b1, B);
    drive(1'b0, B);
    drive(1'b1, B / 2);
    reset_n = 1'b0;
    #1;
    check("midreset_read_data", io_read_data, 32'h0);
    check("midreset_avail", {31'b0, rx_data_avail}, 32'h0);
    q.delete();
    m_ferr = 1'b0; m_ovr = 1'b0;
    uart_rx = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    drive(1'b1, 2 * B);
    read_status("postreset_status");
    nb = 8'($urandom_range(0, 255));
    send_frame(nb, 1'b1);
    model_push(nb);
    drive(1'b1, B);
    read_data("postreset_data");

    // Random mix of frames and reads.
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 4);
      if (r <= 1) begin
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b1);
        model_push(b);
        drive(1'b1, $urandom_range(2, B));
      end else if (r == 2) begin
        read_data($sformatf("rand_data%0d", n));
        drive(1'b1, $urandom_range(1, 5));
        check($sformatf("rand_hold%0d", n), io_read_data, last_exp);
      end else if (r == 3) begin
        read_status($sformatf("rand_status%0d", n));
      end else begin
        addr = $urandom;
        if (addr == STATUS_A || addr == DATA_A) addr = 32'h20;
        io_read(addr, d);
        check($sformatf("rand_other%0d", n), d, 32'h0);
      end
    end
    read_status("final_status");
    while (q.size() != 0) read_data("final_drain");
    check("final_avail", {31'b0, rx_data_avail}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
